// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: z = x - y (mod 2^WIDTH), one bit per clock,
// LSB first, built around a single full-subtractor cell and a borrow flop.
// A start/busy/done handshake sequences operands; z/borrow hold between ops.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bi_q, bi_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;

  logic             a_bit, b_bit, d_bit, bo_bit;

  // Full-subtractor cell working on the current LSBs of the operand copies.
  assign a_bit  = a_q[0];
  assign b_bit  = b_q[0];
  assign d_bit  = a_bit ^ b_bit ^ bi_q;
  assign bo_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bi_q);

  // Next-state logic: operand capture in IDLE, one bit per clock in RUN.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    z_d      = z_q;
    cnt_d    = cnt_q;
    bi_d     = bi_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = x;
          b_d     = y;
          res_d   = '0;
          bi_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        bi_d  = bo_bit;
        cnt_d = cnt_q + 1'b1;
        // Last bit: publish the completed word together with the final borrow.
        if (cnt_q == LAST) begin
          z_d      = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bo_bit;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears every register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      z_q      <= '0;
      cnt_q    <= '0;
      bi_q     <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      z_q      <= z_d;
      cnt_q    <= cnt_d;
      bi_q     <= bi_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign z      = z_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=2 instances, expected results
// from plain x-y arithmetic pushed to queues and checked by monitors on done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] z;
    logic       b;
    int         t;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  // WIDTH=8 instance
  logic       reset8, start8, busy8, done8, borrow8;
  logic [7:0] x8, y8, z8;
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .z(z8), .borrow(borrow8)
  );

  // WIDTH=2 instance
  logic       reset2, start2, busy2, done2, borrow2;
  logic [1:0] x2, y2, z2;
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .z(z2), .borrow(borrow2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for WIDTH=8: result, latency, pulse width, hold-between-ops.
  logic [7:0] last_z8 = '0;
  logic       last_b8 = 1'b0;
  logic       prev_done8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset8) begin
      last_z8 = '0;
      last_b8 = 1'b0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("w8_z", 32'(z8), 32'(e.z));
        chk("w8_borrow", 32'(borrow8), 32'(e.b));
        chk("w8_latency", 32'(cyc - e.t), 32'd8);
      end
      chk("w8_done_width", 32'(prev_done8), 32'd0);
      last_z8 = z8;
      last_b8 = borrow8;
    end else begin
      chk("w8_hold", {23'd0, borrow8, z8}, {23'd0, last_b8, last_z8});
    end
    prev_done8 = done8;
  end

  // Monitor for WIDTH=2.
  logic [1:0] last_z2 = '0;
  logic       last_b2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset2) begin
      last_z2 = '0;
      last_b2 = 1'b0;
    end else if (done2) begin
      if (q2.size() == 0) begin
        chk("w2_unexpected_done", 32'(done2), 32'd0);
      end else begin
        e = q2.pop_front();
        chk("w2_z", 32'(z2), 32'(e.z));
        chk("w2_borrow", 32'(borrow2), 32'(e.b));
        chk("w2_latency", 32'(cyc - e.t), 32'd2);
      end
      last_z2 = z2;
      last_b2 = borrow2;
    end else begin
      chk("w2_hold", {29'd0, borrow2, z2}, {29'd0, last_b2, last_z2});
    end
  end

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input int t);
    exp_t e;
    e.z = 8'((int'(a) - int'(b) + 256) % 256);
    e.b = (a < b);
    e.t = t;
    return e;
  endfunction

  // One WIDTH=8 operation; optionally pulse start and wiggle x/y while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit glitch);
    x8 = a; y8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model8(a, b, cyc));
    start8 = 1'b0;
    @(negedge clk);
    chk("w8_busy_start", 32'(busy8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (glitch) begin
        start8 = (i == 2);
        x8 = (i == 2) ? 8'd1 : 8'($urandom);
        y8 = (i == 2) ? 8'd2 : 8'($urandom);
      end
    end
    start8 = 1'b0;
    @(negedge clk);
    chk("w8_busy_end", 32'(busy8), 32'd0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    x2 = a; y2 = b; start2 = 1'b1;
    @(posedge clk); #1;
    e.z = {6'd0, 2'(a - b)};
    e.b = (a < b);
    e.t = cyc;
    q2.push_back(e);
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset8 = 1'b1; start8 = 1'b0; x8 = '0; y8 = '0;
    reset2 = 1'b1; start2 = 1'b0; x2 = '0; y2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset8 = 1'b0; reset2 = 1'b0;
    @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_z8", 32'(z8), 32'd0);
    chk("rst_borrow8", 32'(borrow8), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_z2", 32'(z2), 32'd0);

    // WIDTH=2: every operand pair.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        op2(2'(a), 2'(b));

    // WIDTH=8 directed edge cases.
    op8(8'h00, 8'h01, 1'b0);
    op8(8'hA5, 8'h5A, 1'b0);
    op8(8'h3C, 8'h3C, 1'b0);
    op8(8'hFF, 8'h00, 1'b0);
    op8(8'd200, 8'd100, 1'b1);

    // Back-to-back: start held high through the done cycle.
    x8 = 8'd17; y8 = 8'd90; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model8(8'd17, 8'd90, cyc));
    start8 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    x8 = 8'd250; y8 = 8'd6; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_busy_done_cycle", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    q8.push_back(model8(8'd250, 8'd6, cyc));
    start8 = 1'b0;
    @(negedge clk);
    chk("b2b_busy_second", 32'(busy8), 32'd1);
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of an operation: no done, everything cleared.
    x8 = 8'd77; y8 = 8'd99; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset8 = 1'b1;
    @(posedge clk); #1;
    reset8 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_z", 32'(z8), 32'd0);
    chk("midrst_borrow", 32'(borrow8), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    op8(8'd99, 8'd77, 1'b0);

    // Randomized operations, some with start/x/y disturbance while busy.
    for (int n = 0; n < 30; n++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("w8_pending", 32'(q8.size()), 32'd0);
    chk("w2_pending", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
